// File: rtl/ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared definitions for the instruction fetch unit: datapath widths,
// fetch FSM state encoding, reset PC and the sequential instruction step.
// ---------------------------------------------------------------------------
package ifu_fetch_pkg;

    localparam int ImmWidth  = 64;
    localparam int InstWidth = 32;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_DROP = 3'd3,
        IFU_HOLD = 3'd4
    } ifu_state_e;

    localparam logic [ImmWidth-1:0] IFU_RESET_PC  = 64'h0000_0000_8000_0000;
    localparam logic [ImmWidth-1:0] IFU_INST_STEP = 64'd4;

endpackage

// File: rtl/ifu_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pc_gen
// Architectural fetch PC register and next-PC selection.
// Priority: redirect target (word aligned) > sequential pc+4 > hold.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset (pc -> RESET_PC)
//   redirect_i     load redirect target this cycle
//   redirect_pc_i  redirect target; low two bits are cleared
//   advance_i      step to the next sequential instruction
//   pc_o           current fetch PC
// ---------------------------------------------------------------------------
module ifu_fetch_pc_gen
    import ifu_fetch_pkg::*;
#(
    parameter int                    PC_WIDTH = ImmWidth,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(IFU_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_i,
    input  logic [PC_WIDTH-1:0]  redirect_pc_i,
    input  logic                 advance_i,
    output logic [PC_WIDTH-1:0]  pc_o
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(IFU_INST_STEP);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        end else if (advance_i) begin
            // Natural modulo-2^PC_WIDTH wrap.
            pc_d = pc_q + STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch stage. Issues one outstanding request at a time to
// instruction memory (valid/ready request, valid-only response), presents
// the fetched PC/instruction pair downstream under valid/ready, and follows
// control-flow redirects, discarding any response that belongs to the old
// path.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req_*        request channel (valid/ready, word-aligned address)
//   imem_rsp_*        response channel (valid only, never back-pressured)
//   redirect_*        branch/jump redirect from execute
//   out_*             PC/instruction pair toward IF/ID (valid/ready)
//   inst_cnt          number of instructions delivered downstream
// ---------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                    PC_WIDTH   = ImmWidth,
    parameter int                    INST_WIDTH = InstWidth,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(IFU_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]  imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INST_WIDTH-1:0]  out_inst,
    output logic [63:0]            inst_cnt
);

    ifu_state_e            state_q;
    ifu_state_e            state_d;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   out_pc_q;
    logic [INST_WIDTH-1:0] inst_buf_q;
    logic [63:0]           inst_cnt_q;

    logic                  redirect_take;
    logic                  advance;
    logic                  buf_load;

    ifu_fetch_pc_gen #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_take),
        .redirect_pc_i (redirect_pc),
        .advance_i     (advance),
        .pc_o          (pc)
    );

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;
        redirect_take  = 1'b0;
        advance        = 1'b0;
        buf_load       = 1'b0;

        case (state_q)
            IFU_IDLE: begin
                state_d = IFU_REQ;
            end

            IFU_REQ: begin
                imem_req_valid = 1'b1;
                redirect_take  = redirect_valid;
                // A request accepted in the same cycle as a redirect is
                // already on the wrong path: its response must be dropped.
                if (imem_req_ready) begin
                    state_d = redirect_valid ? IFU_DROP : IFU_WAIT;
                end
            end

            IFU_WAIT: begin
                if (redirect_valid) begin
                    redirect_take = 1'b1;
                    state_d       = imem_rsp_valid ? IFU_REQ : IFU_DROP;
                end else if (imem_rsp_valid) begin
                    buf_load = 1'b1;
                    state_d  = IFU_HOLD;
                end
            end

            IFU_DROP: begin
                redirect_take = redirect_valid;
                if (imem_rsp_valid) begin
                    state_d = IFU_REQ;
                end
            end

            IFU_HOLD: begin
                // A redirect kills the held instruction in the same cycle.
                out_valid = ~redirect_valid;
                if (redirect_valid) begin
                    redirect_take = 1'b1;
                    state_d       = IFU_REQ;
                end else if (out_ready) begin
                    advance = 1'b1;
                    state_d = IFU_REQ;
                end
            end

            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IFU_IDLE;
            out_pc_q   <= RESET_PC;
            inst_buf_q <= '0;
            inst_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            // out_pc/out_inst are captured together on entry to HOLD, so
            // they keep the last presented pair after leaving HOLD even
            // though the fetch PC has moved on.
            if (buf_load) begin
                out_pc_q   <= pc;
                inst_buf_q <= imem_rsp_data;
            end
            if (advance) begin
                inst_cnt_q <= inst_cnt_q + 64'd1;
            end
        end
    end

    assign imem_req_addr = pc;
    assign out_pc        = out_pc_q;
    assign out_inst      = inst_buf_q;
    assign inst_cnt      = inst_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [63:0] inst_cnt;

    int n_tests;
    int n_fail;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .inst_cnt       (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // ---------------- reset values ----------------
        #12;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'h8000_0000);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_inst_cnt", inst_cnt, 64'd0);
        chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
        tick();
        rst = 1'b0;

        // ---------------- basic fetch ----------------
        tick();                                  // IDLE -> REQ
        chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_req_addr", imem_req_addr, 64'h8000_0000);
        imem_req_ready = 1'b1;
        tick();                                  // fire -> WAIT
        chk("t1_wait_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t1_wait_out_valid", 64'(out_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();                                  // -> HOLD
        imem_rsp_valid = 1'b0;
        out_ready      = 1'b1;
        settle();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_pc", out_pc, 64'h8000_0000);
        chk("t1_out_inst", 64'(out_inst), 64'h13);
        tick();                                  // handshake -> REQ
        chk("t1_next_addr", imem_req_addr, 64'h8000_0004);
        chk("t1_next_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_inst_cnt", inst_cnt, 64'd1);
        chk("t1_after_out_valid", 64'(out_valid), 64'd0);

        // ---------------- stall in HOLD ----------------
        out_ready = 1'b0;
        tick();                                  // fire -> WAIT
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        tick();                                  // -> HOLD
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t2_stall_out_valid", 64'(out_valid), 64'd1);
            chk("t2_stall_out_pc", out_pc, 64'h8000_0004);
            chk("t2_stall_out_inst", 64'(out_inst), 64'h0010_0093);
            chk("t2_stall_req_valid", 64'(imem_req_valid), 64'd0);
            chk("t2_stall_cnt", inst_cnt, 64'd1);
            if (i < 4) tick();
        end
        out_ready = 1'b1;
        tick();                                  // single handshake -> REQ
        chk("t2_release_cnt", inst_cnt, 64'd2);
        chk("t2_release_addr", imem_req_addr, 64'h8000_0008);
        chk("t2_release_out_valid", 64'(out_valid), 64'd0);
        tick();                                  // fire -> WAIT
        chk("t2_no_second_count", inst_cnt, 64'd2);

        // ---------------- redirect in WAIT ----------------
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        settle();
        chk("t3_wait_req_valid", 64'(imem_req_valid), 64'd0);
        tick();                                  // -> DROP
        redirect_valid = 1'b0;
        settle();
        chk("t3_drop_req_valid", 64'(imem_req_valid), 64'd0);
        tick();                                  // still DROP
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        settle();
        chk("t3_drop_out_valid", 64'(out_valid), 64'd0);
        tick();                                  // stale rsp dropped -> REQ
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        settle();
        chk("t3_out_inst_not_stale", 64'(out_inst), 64'h0010_0093);
        chk("t3_out_valid", 64'(out_valid), 64'd0);
        chk("t3_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t3_req_addr", imem_req_addr, 64'h8000_1000);
        chk("t3_cnt", inst_cnt, 64'd2);

        // ---------------- redirect in HOLD ----------------
        tick();                                  // fire -> WAIT
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        tick();                                  // -> HOLD
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        settle();
        chk("t4_hold_redirect_out_valid", 64'(out_valid), 64'd0);
        tick();                                  // -> REQ
        redirect_valid = 1'b0;
        settle();
        chk("t4_cnt", inst_cnt, 64'd2);
        chk("t4_req_addr", imem_req_addr, 64'h8000_0100);
        chk("t4_req_valid", 64'(imem_req_valid), 64'd1);

        // ---------------- backpressure with redirect ----------------
        imem_req_ready = 1'b0;
        settle();
        chk("t5_c1_valid", 64'(imem_req_valid), 64'd1);
        chk("t5_c1_addr", imem_req_addr, 64'h8000_0100);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        settle();
        chk("t5_c2_valid", 64'(imem_req_valid), 64'd1);
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("t5_c3_valid", 64'(imem_req_valid), 64'd1);
        chk("t5_c3_addr", imem_req_addr, 64'h8000_0200);
        tick();
        chk("t5_c4_valid", 64'(imem_req_valid), 64'd1);
        chk("t5_c4_addr", imem_req_addr, 64'h8000_0200);
        imem_req_ready = 1'b1;
        tick();                                  // single fire -> WAIT
        chk("t5_one_req", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_2222;
        tick();                                  // -> HOLD
        imem_rsp_valid = 1'b0;
        settle();
        chk("t5_out_valid", 64'(out_valid), 64'd1);
        chk("t5_out_pc", out_pc, 64'h8000_0200);
        chk("t5_out_inst", 64'(out_inst), 64'h2222_2222);
        tick();                                  // handshake -> REQ
        chk("t5_cnt", inst_cnt, 64'd3);
        chk("t5_next_addr", imem_req_addr, 64'h8000_0204);

        // ---------------- reset while in WAIT ----------------
        tick();                                  // fire -> WAIT
        imem_req_ready = 1'b0;
        settle();
        chk("t6_in_wait", 64'(imem_req_valid), 64'd0);
        rst = 1'b1;
        settle();
        chk("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_out_pc", out_pc, 64'h8000_0000);
        chk("t6_rst_out_inst", 64'(out_inst), 64'd0);
        chk("t6_rst_cnt", inst_cnt, 64'd0);
        chk("t6_rst_addr", imem_req_addr, 64'h8000_0000);
        tick();
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;                   // stray response from old request
        imem_rsp_data  = 32'hBADB_AD00;
        settle();
        chk("t6_idle_out_valid", 64'(out_valid), 64'd0);
        tick();                                  // IDLE -> REQ
        settle();
        chk("t6_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t6_req_addr", imem_req_addr, 64'h8000_0000);
        chk("t6_req_out_valid", 64'(out_valid), 64'd0);
        tick();                                  // stray rsp in REQ ignored
        imem_rsp_valid = 1'b0;
        settle();
        chk("t6_still_req", 64'(imem_req_valid), 64'd1);
        chk("t6_out_inst_clean", 64'(out_inst), 64'd0);
        imem_req_ready = 1'b1;
        tick();                                  // fire -> WAIT
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();                                  // -> HOLD
        imem_rsp_valid = 1'b0;
        settle();
        chk("t6_refetch_valid", 64'(out_valid), 64'd1);
        chk("t6_refetch_pc", out_pc, 64'h8000_0000);
        chk("t6_refetch_inst", 64'(out_inst), 64'h13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
